// File: rtl/axi_lite_cfg_sequencer.sv
// Walks a register table and replays each entry as one AXI-Lite write,
// with a per-write timeout that aborts the whole sequence.
module axi_lite_cfg_sequencer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENTRIES = 16,
  parameter int TIMEOUT     = 256,
  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  output logic [IDX_W-1:0]        o_tbl_index,
  input  logic [ADDR_WIDTH-1:0]   i_tbl_addr,
  input  logic [DATA_WIDTH-1:0]   i_tbl_data,
  input  logic                    i_tbl_last,
  output logic                    o_m_axi_awvalid,
  input  logic                    i_m_axi_awready,
  output logic [ADDR_WIDTH-1:0]   o_m_axi_awaddr,
  output logic [2:0]              o_m_axi_awprot,
  output logic                    o_m_axi_wvalid,
  input  logic                    i_m_axi_wready,
  output logic [DATA_WIDTH-1:0]   o_m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] o_m_axi_wstrb,
  input  logic                    i_m_axi_bvalid,
  output logic                    o_m_axi_bready
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_ADDR, S_RESP} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } entry_t;

  localparam logic [15:0]      TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  entry_t           ent_q;
  logic             aw_pend_q, w_pend_q;
  logic [15:0]      to_cnt_q;
  logic             err_q;
  logic [1:0]       done_pipe;

  logic aw_hs, w_hs, b_hs, in_xfer, to_hit, last_entry, finish;

  always_comb begin
    aw_hs      = aw_pend_q & i_m_axi_awready;
    w_hs       = w_pend_q & i_m_axi_wready;
    b_hs       = (state_q == S_RESP) & i_m_axi_bvalid;
    in_xfer    = (state_q == S_ADDR) | (state_q == S_RESP);
    to_hit     = in_xfer & ~b_hs & (to_cnt_q == TO_LAST);
    last_entry = ent_q.last | (idx_q == IDX_LAST);
    finish     = b_hs & last_entry & ~to_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_FETCH;
      S_FETCH: state_d = S_LATCH;
      S_LATCH: state_d = S_ADDR;
      // each channel is done once its own handshake has happened, now or earlier
      S_ADDR: begin
        if (to_hit)
          state_d = S_IDLE;
        else if ((!aw_pend_q || i_m_axi_awready) && (!w_pend_q || i_m_axi_wready))
          state_d = S_RESP;
      end
      S_RESP: begin
        if (to_hit)     state_d = S_IDLE;
        else if (b_hs)  state_d = last_entry ? S_IDLE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q     <= '0;
      ent_q     <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
      done_pipe <= '0;
    end else begin
      // done is reported one cycle after the FSM is back in IDLE
      done_pipe <= {done_pipe[0], finish | to_hit};
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            idx_q <= '0;
            err_q <= 1'b0;
          end
        end
        S_LATCH: begin
          ent_q     <= '{addr: i_tbl_addr, data: i_tbl_data, last: i_tbl_last};
          to_cnt_q  <= '0;
          aw_pend_q <= 1'b1;
          w_pend_q  <= 1'b1;
        end
        S_ADDR, S_RESP: begin
          if (to_hit) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            err_q     <= 1'b1;
          end else begin
            if (aw_hs) aw_pend_q <= 1'b0;
            if (w_hs)  w_pend_q  <= 1'b0;
            if (!b_hs) to_cnt_q  <= to_cnt_q + 16'd1;
            if (b_hs && !last_entry) idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy          = (state_q != S_IDLE);
    o_done          = done_pipe[1];
    o_error         = err_q;
    o_tbl_index     = idx_q;
    o_m_axi_awvalid = aw_pend_q;
    o_m_axi_awaddr  = ent_q.addr;
    o_m_axi_awprot  = 3'b000;
    o_m_axi_wvalid  = w_pend_q;
    o_m_axi_wdata   = ent_q.data;
    o_m_axi_wstrb   = '1;
    o_m_axi_bready  = (state_q == S_RESP);
  end

endmodule

// File: tb/tb_axi_lite_cfg_sequencer.sv
// Scoreboard bench: table model + reactive AXI-Lite slave, expected writes
// queued when a sequence is launched and popped as write handshakes complete.
`timescale 1ns/1ps
module tb_axi_lite_cfg_sequencer;
  localparam int AW = 32, DW = 32, NE = 4, TO = 16, IW = 2;

  logic          clk, reset, i_start;
  logic          o_busy, o_done, o_error;
  logic [IW-1:0] o_tbl_index;
  logic [AW-1:0] i_tbl_addr;
  logic [DW-1:0] i_tbl_data;
  logic          i_tbl_last;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;

  axi_lite_cfg_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ENTRIES(NE), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_tbl_index(o_tbl_index), .i_tbl_addr(i_tbl_addr), .i_tbl_data(i_tbl_data), .i_tbl_last(i_tbl_last),
    .o_m_axi_awvalid(awvalid), .i_m_axi_awready(awready), .o_m_axi_awaddr(awaddr), .o_m_axi_awprot(awprot),
    .o_m_axi_wvalid(wvalid), .i_m_axi_wready(wready), .o_m_axi_wdata(wdata), .o_m_axi_wstrb(wstrb),
    .i_m_axi_bvalid(bvalid), .o_m_axi_bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] t_addr [NE];
  logic [DW-1:0] t_data [NE];
  logic          t_last [NE];

  // synchronous table read: data follows the index by one cycle
  always @(posedge clk) begin
    i_tbl_addr <= t_addr[o_tbl_index];
    i_tbl_data <= t_data[o_tbl_index];
    i_tbl_last <= t_last[o_tbl_index];
  end

  int n_checks, n_fail;
  int aw_lat, w_lat, b_lat, aw_c, w_c, b_c;
  bit aw_stuck;
  int n_writes, n_aw_cyc, n_br_cyc, n_done;
  logic [AW+DW-1:0] exp_q [$];
  logic [AW-1:0]    got_a [$];
  logic [DW-1:0]    got_d [$];
  logic [IW-1:0]    idx_log [$];
  logic [AW+DW-1:0] wr, ex;

  task automatic load_table(input int last_at);
    for (int i = 0; i < NE; i++) begin
      t_addr[i] = 32'h4000_0000 + 32'(i * 8);
      t_data[i] = $urandom;
      t_last[i] = (i == last_at);
    end
  endtask

  task automatic clear_sb();
    exp_q.delete(); got_a.delete(); got_d.delete(); idx_log.delete();
    n_writes = 0; n_aw_cyc = 0; n_br_cyc = 0; n_done = 0;
  endtask

  task automatic expect_entries(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({t_addr[i], t_data[i]});
  endtask

  // start is sampled on "edge 0"; returns at the following negedge
  task automatic pulse_start();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({o_busy, o_done, o_error, awvalid, wvalid, bready} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 000000", {o_busy, o_done, o_error, awvalid, wvalid, bready});
    end
    n_checks++;
    if ({o_tbl_index, awaddr, wdata} !== '0) begin
      n_fail++; $display("FAIL reset_data: got idx %0d addr %h data %h required 0", o_tbl_index, awaddr, wdata);
    end
    n_checks++;
    if (awprot !== 3'b000 || wstrb !== 4'hf) begin
      n_fail++; $display("FAIL reset_const: got prot %b strb %h required 000 f", awprot, wstrb);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_basic();
    int t_done = -1;
    logic busy_at = 1'b1, err_at = 1'b1;
    load_table(2); clear_sb(); expect_entries(3);
    pulse_start();
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (o_done && t_done < 0) begin t_done = k; busy_at = o_busy; err_at = o_error; end
    end
    n_checks++;
    if (t_done !== 13) begin n_fail++; $display("FAIL basic_done_cycle: got %0d required 13", t_done); end
    n_checks++;
    if (busy_at !== 1'b0 || err_at !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_flags: got busy %b err %b required 0 0", busy_at, err_at);
    end
    n_checks++;
    if (n_writes !== 3 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL basic_writes: got %0d writes %0d left required 3 0", n_writes, exp_q.size());
    end
    n_checks++;
    if (n_br_cyc !== 3 || n_done !== 1) begin
      n_fail++; $display("FAIL basic_bready_done: got bready %0d done %0d required 3 1", n_br_cyc, n_done);
    end
  endtask

  task automatic test_timeout();
    int t_done = -1;
    logic err_at = 1'b0, busy_at = 1'b1;
    load_table(-1); clear_sb(); aw_stuck = 1'b1;
    pulse_start();
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (o_done && t_done < 0) begin t_done = k; err_at = o_error; busy_at = o_busy; end
    end
    n_checks++;
    if (n_aw_cyc !== TO) begin n_fail++; $display("FAIL timeout_aw_cycles: got %0d required %0d", n_aw_cyc, TO); end
    n_checks++;
    if (t_done !== 19) begin n_fail++; $display("FAIL timeout_done_cycle: got %0d required 19", t_done); end
    n_checks++;
    if (err_at !== 1'b1 || busy_at !== 1'b0 || n_done !== 1) begin
      n_fail++; $display("FAIL timeout_flags: got err %b busy %b done %0d required 1 0 1", err_at, busy_at, n_done);
    end
    n_checks++;
    if (o_error !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0 || n_writes !== 0) begin
      n_fail++; $display("FAIL timeout_sticky: got err %b aw %b w %b writes %0d required 1 0 0 0", o_error, awvalid, wvalid, n_writes);
    end
    aw_stuck = 1'b0;
  endtask

  task automatic test_w_lag();
    int t_done = -1;
    logic [2:0] exp_v;
    load_table(0); clear_sb(); expect_entries(1); w_lat = 5;
    pulse_start();
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        n_checks++;
        if (o_error !== 1'b0) begin n_fail++; $display("FAIL wlag_error_cleared: got %b required 0", o_error); end
      end
      if (k >= 2 && k <= 8) begin
        exp_v = {k == 2, k <= 7, k == 8};
        n_checks++;
        if ({awvalid, wvalid, bready} !== exp_v) begin
          n_fail++; $display("FAIL wlag_valids_k%0d: got aw/w/br %b required %b", k, {awvalid, wvalid, bready}, exp_v);
        end
        if (wvalid) begin
          n_checks++;
          if (wdata !== t_data[0]) begin n_fail++; $display("FAIL wlag_wdata_k%0d: got %h required %h", k, wdata, t_data[0]); end
        end
      end
      if (o_done && t_done < 0) t_done = k;
    end
    n_checks++;
    if (t_done !== 10 || n_writes !== 1) begin
      n_fail++; $display("FAIL wlag_finish: got done %0d writes %0d required 10 1", t_done, n_writes);
    end
    w_lat = 0;
  endtask

  task automatic test_no_last();
    int t_done = -1;
    load_table(-1); clear_sb(); expect_entries(NE);
    pulse_start();
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (o_done && t_done < 0) t_done = k;
    end
    n_checks++;
    if (t_done !== 17 || n_writes !== NE || n_done !== 1) begin
      n_fail++; $display("FAIL nolast_finish: got done %0d writes %0d pulses %0d required 17 4 1", t_done, n_writes, n_done);
    end
    n_checks++;
    if (idx_log.size() !== NE) begin
      n_fail++; $display("FAIL nolast_idx_count: got %0d required %0d", idx_log.size(), NE);
    end else begin
      for (int i = 0; i < NE; i++) begin
        n_checks++;
        if (idx_log[i] !== IW'(i)) begin n_fail++; $display("FAIL nolast_idx_%0d: got %0d required %0d", i, idx_log[i], i); end
      end
    end
  endtask

  task automatic test_start_ignored();
    int t_done = -1;
    load_table(2); clear_sb(); expect_entries(3);
    pulse_start();
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (o_done && t_done < 0) t_done = k;
      i_start = (k == 3 || k == 7 || k == 10);
    end
    i_start = 1'b0;
    n_checks++;
    if (t_done !== 13 || n_writes !== 3 || n_done !== 1 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL start_ignored: got done %0d writes %0d pulses %0d left %0d required 13 3 1 0",
                         t_done, n_writes, n_done, exp_q.size());
    end
  endtask

  task automatic test_reset_in_resp();
    bit seen = 1'b0;
    int t_done = -1;
    load_table(2); clear_sb(); expect_entries(1); b_lat = 2;
    pulse_start();
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bready && bvalid) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rst_resp_wait: got no bvalid in RESP required one within 40 cycles"); end
    reset = 1'b1; #1;
    n_checks++;
    if ({o_busy, o_done, o_error, awvalid, wvalid, bready} !== 6'b0 || {o_tbl_index, awaddr, wdata} !== '0) begin
      n_fail++; $display("FAIL rst_resp_outputs: got ctrl %b idx %0d addr %h data %h required all 0",
                         {o_busy, o_done, o_error, awvalid, wvalid, bready}, o_tbl_index, awaddr, wdata);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rst_resp_first_write: got %0d pending required 0", exp_q.size()); end
    @(negedge clk); reset = 1'b0; b_lat = 0;
    clear_sb(); expect_entries(3);
    pulse_start();
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (o_done && t_done < 0) t_done = k;
    end
    n_checks++;
    if (t_done !== 13 || n_writes !== 3 || idx_log.size() == 0 || idx_log[0] !== '0) begin
      n_fail++; $display("FAIL rst_resp_restart: got done %0d writes %0d required 13 3 from index 0", t_done, n_writes);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; i_start = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    aw_lat = 0; w_lat = 0; b_lat = 0; aw_c = 0; w_c = 0; b_c = 0; aw_stuck = 1'b0;
    load_table(-1); clear_sb();
    fork
      // slave reacts shortly after each edge so handshakes are stable by the next one
      forever begin
        @(posedge clk); #2;
        if (awvalid) begin awready = !aw_stuck && (aw_c >= aw_lat); aw_c++; end
        else begin awready = 1'b0; aw_c = 0; end
        if (wvalid) begin wready = (w_c >= w_lat); w_c++; end
        else begin wready = 1'b0; w_c = 0; end
        if (bready) begin bvalid = (b_c >= b_lat); b_c++; end
        else begin bvalid = 1'b0; b_c = 0; end
      end
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (awvalid) n_aw_cyc++;
          if (bready)  n_br_cyc++;
          if (o_done)  n_done++;
          if (awvalid && awready) begin got_a.push_back(awaddr); idx_log.push_back(o_tbl_index); end
          if (wvalid && wready) got_d.push_back(wdata);
          if (got_a.size() > 0 && got_d.size() > 0) begin
            wr = {got_a.pop_front(), got_d.pop_front()};
            n_writes++;
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL sb_unexpected_write: got %h required none", wr);
            end else begin
              ex = exp_q.pop_front();
              if (wr !== ex) begin n_fail++; $display("FAIL sb_write: got %h required %h", wr, ex); end
            end
          end
        end
      end
    join_none
    test_reset();
    test_basic();
    test_timeout();
    test_w_lag();
    test_no_last();
    test_start_ignored();
    test_reset_in_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
